// File: rtl/ra_bist_march.sv
// March C- BIST engine for a 1W/2R register array; passes functional ports
// through to the array when idle, owns all three ports while a run is active.
module ra_bist_march #(
  parameter int ADR_W  = 5,
  parameter int DAT_W  = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      bist_ctl,
  output logic [31:0]      bist_status,
  input  logic             f_rd_enb_0,
  input  logic [ADR_W-1:0] f_rd_adr_0,
  input  logic             f_rd_enb_1,
  input  logic [ADR_W-1:0] f_rd_adr_1,
  input  logic             f_wr_enb_0,
  input  logic [ADR_W-1:0] f_wr_adr_0,
  input  logic [DAT_W-1:0] f_wr_dat_0,
  output logic [DAT_W-1:0] f_rd_dat_0,
  output logic [DAT_W-1:0] f_rd_dat_1,
  output logic             rd_enb_0,
  output logic [ADR_W-1:0] rd_adr_0,
  output logic             rd_enb_1,
  output logic [ADR_W-1:0] rd_adr_1,
  output logic             wr_enb_0,
  output logic [ADR_W-1:0] wr_adr_0,
  output logic [DAT_W-1:0] wr_dat_0,
  input  logic [DAT_W-1:0] rd_dat_0,
  input  logic [DAT_W-1:0] rd_dat_1
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic             v;
    logic [DAT_W-1:0] exp;
    logic [2:0]       elem;
    logic [ADR_W-1:0] adr;
  } rd_tag_t;

  state_t           state;
  logic             start_q;
  logic [1:0]       bg_sel;
  logic             stop_on_fail;
  logic [2:0]       elem;
  logic [ADR_W-1:0] adr;
  logic             phase;
  logic [1:0]       drain_cnt;
  rd_tag_t          pipe [RD_LAT];
  logic             fail, fport;
  logic [2:0]       felem;
  logic [7:0]       fadr, ecnt;

  logic             start_edge, abort;
  logic [DAT_W-1:0] bg_word;
  logic             rw_elem, op_rd, op_wr, wr_one, rd_one, down, last_adr;
  logic             mis0, mis1;
  logic [1:0]       err_add;
  logic [8:0]       err_sum;
  logic             unused_ctl;

  assign unused_ctl = ^bist_ctl[31:5];
  assign start_edge = bist_ctl[0] & ~start_q;
  assign abort      = bist_ctl[1];

  always_comb begin
    bg_word = '0;
    case (bg_sel)
      2'd1:    bg_word = {(DAT_W/2){2'b01}};
      2'd2:    bg_word = {(DAT_W/4){4'b0011}};
      2'd3:    bg_word = {(DAT_W/8){8'h0F}};
      default: bg_word = '0;
    endcase
  end

  // Elements 1..4 alternate a read cycle (phase 0) and a write cycle (phase 1) per address.
  assign rw_elem  = (elem >= 3'd1) && (elem <= 3'd4);
  assign op_rd    = (state == RUN) && ((elem == 3'd5) || (rw_elem && !phase));
  assign op_wr    = (state == RUN) && ((elem == 3'd0) || (rw_elem && phase));
  assign wr_one   = (elem == 3'd1) || (elem == 3'd3);
  assign rd_one   = (elem == 3'd2) || (elem == 3'd4);
  assign down     = (elem == 3'd3) || (elem == 3'd4);
  assign last_adr = down ? (adr == '0) : (adr == '1);

  assign mis0    = pipe[RD_LAT-1].v && (rd_dat_0 != pipe[RD_LAT-1].exp);
  assign mis1    = pipe[RD_LAT-1].v && (rd_dat_1 != pipe[RD_LAT-1].exp);
  assign err_add = {1'b0, mis0} + {1'b0, mis1};
  assign err_sum = {1'b0, ecnt} + {7'b0, err_add};

  assign f_rd_dat_0  = rd_dat_0;
  assign f_rd_dat_1  = rd_dat_1;
  assign bist_status = {ecnt, 8'h00, fadr, 1'b0, felem, fport, fail,
                        state == DONE, (state == RUN) || (state == DRAIN)};

  always_comb begin
    rd_enb_0 = 1'b0;
    rd_adr_0 = '0;
    rd_enb_1 = 1'b0;
    rd_adr_1 = '0;
    wr_enb_0 = 1'b0;
    wr_adr_0 = '0;
    wr_dat_0 = '0;
    case (state)
      IDLE, DONE: begin
        rd_enb_0 = f_rd_enb_0;
        rd_adr_0 = f_rd_adr_0;
        rd_enb_1 = f_rd_enb_1;
        rd_adr_1 = f_rd_adr_1;
        wr_enb_0 = f_wr_enb_0;
        wr_adr_0 = f_wr_adr_0;
        wr_dat_0 = f_wr_dat_0;
      end
      RUN: begin
        rd_enb_0 = op_rd;
        rd_adr_0 = adr;
        rd_enb_1 = op_rd;
        rd_adr_1 = adr;
        wr_enb_0 = op_wr;
        wr_adr_0 = adr;
        wr_dat_0 = wr_one ? ~bg_word : bg_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      bg_sel       <= '0;
      stop_on_fail <= 1'b0;
      elem         <= '0;
      adr          <= '0;
      phase        <= 1'b0;
      drain_cnt    <= '0;
      fail         <= 1'b0;
      fport        <= 1'b0;
      felem        <= '0;
      fadr         <= '0;
      ecnt         <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      start_q <= bist_ctl[0];

      pipe[0] <= '{v: op_rd, exp: rd_one ? ~bg_word : bg_word, elem: elem, adr: adr};
      for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];

      if (mis0 || mis1) begin
        ecnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        if (!fail) begin
          fail  <= 1'b1;
          fport <= !mis0;
          felem <= pipe[RD_LAT-1].elem;
          fadr  <= 8'(pipe[RD_LAT-1].adr);
        end
      end

      case (state)
        RUN: begin
          if (rw_elem && !phase) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (last_adr) begin
              if (elem == 3'd5) begin
                state     <= DRAIN;
                drain_cnt <= 2'(RD_LAT - 1);
              end else begin
                elem <= elem + 3'd1;
                adr  <= ((elem == 3'd2) || (elem == 3'd3)) ? '1 : '0;
              end
            end else begin
              adr <= down ? adr - 1'b1 : adr + 1'b1;
            end
          end
          if (stop_on_fail && (mis0 || mis1)) begin
            state     <= DRAIN;
            drain_cnt <= 2'(RD_LAT - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= DONE;
          else drain_cnt <= drain_cnt - 2'd1;
        end
        default: ;
      endcase

      // Abort wins over start; compares still in flight are discarded.
      if (abort) begin
        state <= IDLE;
        for (int unsigned i = 0; i < RD_LAT; i++) pipe[i].v <= 1'b0;
      end else if (start_edge && ((state == IDLE) || (state == DONE))) begin
        state        <= RUN;
        bg_sel       <= bist_ctl[3:2];
        stop_on_fail <= bist_ctl[4];
        elem         <= '0;
        adr          <= '0;
        phase        <= 1'b0;
        fail         <= 1'b0;
        fport        <= 1'b0;
        felem        <= '0;
        fadr         <= '0;
        ecnt         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ra_bist_march.sv
// Bench for ra_bist_march: array model with optional stuck-at-0 cell, March C-
// reference model built from the element list, and a per-cycle compare process.
module tb_ra_bist_march;
  localparam int ADR_W = 5, DAT_W = 32, RD_LAT = 1, DEPTH = 32, NOPS = 320;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [31:0]      bist_ctl, bist_status;
  logic             f_rd_enb_0, f_rd_enb_1, f_wr_enb_0;
  logic [ADR_W-1:0] f_rd_adr_0, f_rd_adr_1, f_wr_adr_0;
  logic [DAT_W-1:0] f_wr_dat_0, f_rd_dat_0, f_rd_dat_1;
  logic             rd_enb_0, rd_enb_1, wr_enb_0;
  logic [ADR_W-1:0] rd_adr_0, rd_adr_1, wr_adr_0;
  logic [DAT_W-1:0] wr_dat_0, rd_dat_0, rd_dat_1;

  ra_bist_march #(.ADR_W(ADR_W), .DAT_W(DAT_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .bist_ctl(bist_ctl), .bist_status(bist_status),
    .f_rd_enb_0(f_rd_enb_0), .f_rd_adr_0(f_rd_adr_0),
    .f_rd_enb_1(f_rd_enb_1), .f_rd_adr_1(f_rd_adr_1),
    .f_wr_enb_0(f_wr_enb_0), .f_wr_adr_0(f_wr_adr_0), .f_wr_dat_0(f_wr_dat_0),
    .f_rd_dat_0(f_rd_dat_0), .f_rd_dat_1(f_rd_dat_1),
    .rd_enb_0(rd_enb_0), .rd_adr_0(rd_adr_0),
    .rd_enb_1(rd_enb_1), .rd_adr_1(rd_adr_1),
    .wr_enb_0(wr_enb_0), .wr_adr_0(wr_adr_0), .wr_dat_0(wr_dat_0),
    .rd_dat_0(rd_dat_0), .rd_dat_1(rd_dat_1)
  );

  // Array: one-cycle registered reads; optional stuck-at-0 on bit 5 of word 7.
  logic [DAT_W-1:0] mem [DEPTH];
  bit fault_on = 1'b0;
  always @(posedge clk) begin
    if (wr_enb_0)
      mem[wr_adr_0] <= (fault_on && wr_adr_0 == 5'd7) ? (wr_dat_0 & ~32'h20) : wr_dat_0;
    if (rd_enb_0) rd_dat_0 <= mem[rd_adr_0];
    if (rd_enb_1) rd_dat_1 <= mem[rd_adr_1];
  end

  typedef struct packed {
    logic             rd;
    logic             wr;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } op_t;

  op_t         ops [NOPS];
  int          op_elem [NOPS];
  logic [31:0] bgs [4] = '{32'h00000000, 32'h55555555, 32'h33333333, 32'h0F0F0F0F};

  int errors = 0, checks = 0;
  bit chk_en = 1'b0, run_on = 1'b0;
  int t = 0, n_ops = NOPS, cut = 0;
  int busy_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic [31:0] exp_final = '0, prev_final = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", nm, act, exp, t, $time);
    end
  endtask

  function automatic logic [31:0] opw(input logic r0, input logic [ADR_W-1:0] a0,
                                      input logic r1, input logic [ADR_W-1:0] a1,
                                      input logic w, input logic [ADR_W-1:0] wa);
    return {14'b0, r0, r0 ? a0 : 5'd0, r1, r1 ? a1 : 5'd0, w, w ? wa : 5'd0};
  endfunction

  // Expand March C- into an op list, replay it on an ideal (optionally faulty)
  // array and derive the run length and final status word.
  task automatic build_model(input logic [1:0] bg, input bit fault, input bit stop,
                             input int cut_at, input bit is_rst,
                             output int nops_o, output logic [31:0] st);
    logic [DAT_W-1:0] b, m [DEPTH];
    bit   rfail [NOPS];
    int   k, a, first, lim, cnt, fe, fa;
    bit   ff;
    b = bgs[bg];
    k = 0;
    for (int e = 0; e < 6; e++) begin
      for (int j = 0; j < DEPTH; j++) begin
        a = (e == 3 || e == 4) ? DEPTH - 1 - j : j;
        if (e == 0) begin
          ops[k] = '{1'b0, 1'b1, ADR_W'(a), b}; op_elem[k] = e; k++;
        end else if (e == 5) begin
          ops[k] = '{1'b1, 1'b0, ADR_W'(a), b}; op_elem[k] = e; k++;
        end else begin
          ops[k] = '{1'b1, 1'b0, ADR_W'(a), (e == 2 || e == 4) ? ~b : b}; op_elem[k] = e; k++;
          ops[k] = '{1'b0, 1'b1, ADR_W'(a), (e == 1 || e == 3) ? ~b : b}; op_elem[k] = e; k++;
        end
      end
    end
    first = -1;
    for (int i = 0; i < NOPS; i++) begin
      rfail[i] = 1'b0;
      if (ops[i].wr)
        m[ops[i].adr] = (fault && ops[i].adr == 5'd7) ? (ops[i].dat & ~32'h20) : ops[i].dat;
      if (ops[i].rd) begin
        rfail[i] = (m[ops[i].adr] != ops[i].dat);
        if (rfail[i] && first < 0) first = i;
      end
    end
    nops_o = (stop && first >= 0 && first + RD_LAT + 1 < NOPS) ? first + RD_LAT + 1 : NOPS;
    lim = (cut_at > 0) ? cut_at : nops_o + RD_LAT;
    cnt = 0; ff = 1'b0; fe = 0; fa = 0;
    for (int i = 0; i < NOPS; i++) begin
      if (rfail[i] && i + 1 + RD_LAT <= lim) begin
        cnt = (cnt + 2 > 255) ? 255 : cnt + 2;
        if (!ff) begin ff = 1'b1; fe = op_elem[i]; fa = int'(ops[i].adr); end
      end
    end
    st = {8'(cnt), 8'h00, 8'(fa), 1'b0, 3'(fe), 1'b0, ff, cut_at == 0, 1'b0};
    if (is_rst) st = '0;
  endtask

  task automatic chk_idle(input logic [31:0] st);
    chk("pass_ports", opw(rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1, wr_enb_0, wr_adr_0),
        opw(f_rd_enb_0, f_rd_adr_0, f_rd_enb_1, f_rd_adr_1, f_wr_enb_0, f_wr_adr_0));
    chk("pass_wdat", wr_dat_0, f_wr_dat_0);
    chk("status", bist_status, st);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("f_rd_dat_0", f_rd_dat_0, rd_dat_0);
      chk("f_rd_dat_1", f_rd_dat_1, rd_dat_1);
      if (!run_on) begin
        chk_idle(exp_final);
      end else begin
        if (bist_status[0]) busy_cnt++;
        if (t == 0) chk_idle(prev_final);
        else if (cut > 0 && t > cut) chk_idle(exp_final);
        else if (t <= n_ops) begin
          chk("run_op", opw(rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1, wr_enb_0, wr_adr_0),
              opw(ops[t-1].rd, ops[t-1].adr, ops[t-1].rd, ops[t-1].adr, ops[t-1].wr, ops[t-1].adr));
          if (ops[t-1].wr) chk("run_wdat", wr_dat_0, ops[t-1].dat);
          chk("run_busy_done", {30'b0, bist_status[1:0]}, 32'd1);
          if (wr_enb_0) wr_cnt++;
          if (rd_enb_0 && rd_enb_1) rd_cnt++;
        end else if (t <= n_ops + RD_LAT) begin
          chk("drain_quiet", opw(rd_enb_0, rd_adr_0, rd_enb_1, rd_adr_1, wr_enb_0, wr_adr_0), 32'd0);
          chk("drain_busy_done", {30'b0, bist_status[1:0]}, 32'd1);
        end else chk_idle(exp_final);
        t++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      f_rd_enb_0 = 1'($urandom_range(0, 1));
      f_rd_enb_1 = 1'($urandom_range(0, 1));
      f_wr_enb_0 = 1'($urandom_range(0, 1));
      f_rd_adr_0 = ADR_W'($urandom);
      f_rd_adr_1 = ADR_W'($urandom);
      f_wr_adr_0 = ADR_W'($urandom);
      f_wr_dat_0 = $urandom;
    end
  end

  task automatic run_march(input logic [31:0] ctl, input bit fault, input int cut_at, input bit is_rst);
    int nops_v;
    logic [31:0] st_v;
    @(posedge clk); #1;
    bist_ctl = '0;
    fault_on = fault;
    build_model(ctl[3:2], fault, ctl[4], cut_at, is_rst, nops_v, st_v);
    @(posedge clk); #1;
    prev_final = exp_final; exp_final = st_v; n_ops = nops_v; cut = cut_at;
    t = 0; busy_cnt = 0; wr_cnt = 0; rd_cnt = 0; run_on = 1'b1;
    bist_ctl = ctl;
    if (cut_at > 0) begin
      repeat (cut_at) @(posedge clk);
      #1;
      if (is_rst) begin rst = 1'b1; bist_ctl = '0; end
      else bist_ctl = ctl | 32'h2;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
    end else begin
      // Start stays high after completion: no second run may begin.
      repeat (n_ops + RD_LAT + 8) @(posedge clk);
      #1;
      chk("busy_cycles", busy_cnt, n_ops + RD_LAT);
    end
    run_on = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bist_ctl = '0;
    f_rd_enb_0 = 0; f_rd_enb_1 = 0; f_wr_enb_0 = 0;
    f_rd_adr_0 = '0; f_rd_adr_1 = '0; f_wr_adr_0 = '0; f_wr_dat_0 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    run_march(32'h1, 1'b0, 0, 1'b0);
    chk("clean_model", exp_final, 32'h2);
    chk("clean_busy", busy_cnt, 321);
    chk("clean_writes", wr_cnt, 160);
    chk("clean_reads", rd_cnt, 160);
    chk("clean_status", bist_status, 32'h2);

    for (int bg = 1; bg < 4; bg++) begin
      run_march(32'h1 | (32'(bg) << 2), 1'b0, 0, 1'b0);
      chk("bg_status", bist_status, 32'h2);
      if (bg == 1) chk("bg1_e1_write", ops[33].dat, 32'hAAAAAAAA);
    end

    run_march(32'h1, 1'b1, 0, 1'b0);
    chk("sa0_model", exp_final, 32'h04000726);
    chk("sa0_status", bist_status, 32'h04000726);

    run_march(32'h11, 1'b1, 0, 1'b0);
    chk("sof_nops", n_ops, 112);
    chk("sof_status", bist_status, 32'h02000726);

    run_march(32'h1, 1'b1, 150, 1'b0);
    chk("abort_status", bist_status, 32'h02000724);

    run_march(32'h1, 1'b0, 50, 1'b1);
    chk("reset_status", bist_status, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
